mem_cycle_controller: RTL and testbench
=======================================

# mem_cycle_controller

Downstream of the CPU bus interface; consumes its latched bank address, 16-bit address, `_re`/`_we` strobes, vector-pull flag and captured write data. Forms a 24-bit address and decodes it into ROM / RAM / I/O chip selects. Generates per-region wait states by pulling CPU `rdy` low, and drives memory output and write strobes for the length of each bus cycle. Runs on the fast FPGA clock and tracks the CPU cycle through a sampled `phi2` level.

## Interface
- `ROM_WAIT`, 4'd2: wait clocks for ROM accesses.
- `RAM_WAIT`, 4'd0: wait clocks for RAM accesses.
- `IO_WAIT`, 4'd3: wait clocks for I/O accesses.
- `RAM_TOP_BANK`, 8'h07: highest bank backed by RAM; higher banks are unmapped.
- `clk  in  1`: clock `clk`.
- `internal_reset  in  1`: reset `internal_reset`, asynchronous, active-high.
- `phi2  in  1`: CPU phase-2 level, synchronous to `clk`.
- `bank_addr  in  8`: A23..A16.
- `address  in  16`: A15..A0.
- `re_n  in  1`: read enable, active low.
- `we_n  in  1`: write enable, active low.
- `vp_n  in  1`: vector pull, active low.
- `rdy  out  1`: CPU ready, high = proceed.
- `rom_ce_n`, `ram_ce_n`, `io_ce_n  out  1 each`: chip selects, active low.
- `mem_oe_n  out  1`: memory output enable, active low.
- `mem_we_n  out  1`: memory write strobe, active low.
- `region  out  2`: latched region code: 0 = none, 1 = ROM, 2 = RAM, 3 = I/O.
- `cycle_done  out  1`: one-clk pulse at end of each decoded cycle.
- `bus_err  out  1`: sticky error flag; set when `re_n` and `we_n` are both low at cycle start.

## Operation
- Reset values:
  - `rdy` = 1.
  - All `*_ce_n`, `mem_oe_n`, `mem_we_n` = 1.
  - `region` = 0, `cycle_done` = 0, `bus_err` = 0.
  - State IDLE, counter 0, `phi2_q` = 0.
- `phi2_q` registers `phi2` every clk. Cycle start = `phi2 & ~phi2_q`.
- Decode uses `A = {bank_addr, address}`, sampled at cycle start. Rules in priority order:
  1. `vp_n` = 0 → ROM, any bank.
  2. Bank 00, `address` in 16'hDF00..16'hDFFF → I/O.
  3. Bank 00, `address` ≥ 16'hE000 → ROM.
  4. Bank ≤ `RAM_TOP_BANK` → RAM.
  5. Otherwise → none: no CE asserted, 0 wait states.
- Access type is latched at cycle start:
  - `re_n` = 0 → read.
  - `we_n` = 0 (and `re_n` = 1) → write.
  - Both low → read, and `bus_err` <= 1.
  - Both high → idle cycle: stay in IDLE, no outputs change, no `cycle_done`.
- FSM states: IDLE, ACCESS, HOLD.
  - IDLE, on cycle start with read or write:
    - Latch `region`; assert matching CE; `mem_oe_n` = 0 for read or `mem_we_n` = 0 for write.
    - W = region wait (0 for none). Counter <= W; `rdy` <= (W == 0).
    - Next state: HOLD if W = 0, else ACCESS.
  - ACCESS: counter decrements each clk. When counter == 1: counter <= 0, `rdy` <= 1, go to HOLD. A `phi2` fall while in ACCESS is ignored.
  - HOLD: strobes and CE held. When `phi2_q` = 0:
    - Deassert all CE and strobes.
    - `cycle_done` <= 1 for one clk.
    - `region` keeps its value; go to IDLE.
- `bus_err` is cleared only by reset.
- Asserting reset mid-cycle drops all outputs to reset values immediately and aborts the cycle.

## Timing
- Cycle start detected at clk edge N. CE and strobe are asserted from edge N.
- `rdy` is low from edge N through edge N+W-1 and high from edge N+W: exactly W clks low. With W = 0, `rdy` never drops.
- Strobes are released at the first clk edge in HOLD where `phi2_q` = 0. `cycle_done` is high for the following clk only.
- Back-to-back cycles: a new rising edge can be accepted in the clk after returning to IDLE. Minimum IDLE dwell is 1 clk.
- Counter is 4 bits; parameters above 15 are illegal.

## Test plan
- Reset: assert `internal_reset` mid-ACCESS → outputs return to reset values at once; `rdy` = 1, all CE = 1, `bus_err` = 0.
- RAM read, bank 01, addr 1234, `RAM_WAIT` = 0 → `ram_ce_n` = 0 and `mem_oe_n` = 0 at edge N; `rdy` stays 1; `region` = 2; `cycle_done` pulses one clk after `phi2` falls.
- I/O write, bank 00, addr DF10, `IO_WAIT` = 3 → `io_ce_n` = 0 and `mem_we_n` = 0; `rdy` low exactly 3 clks; `region` = 3.
- Vector pull: `vp_n` = 0, bank 05, addr FFEA, read → `rom_ce_n` = 0; `rdy` low 2 clks; `region` = 1.
- Unmapped read, bank 10 → no CE asserted; `mem_oe_n` = 0; `rdy` = 1; `region` = 0. Idle cycle (`re_n` = `we_n` = 1) → no outputs change, no `cycle_done`.
- Both `re_n` and `we_n` low at cycle start → handled as read; `bus_err` = 1 and remains 1 across later cycles until reset.

Source files
------------

// File: rtl/mem_cycle_controller.sv
// -----------------------------------------------------------------------------
// mem_cycle_controller
//
// Sits behind the CPU bus interface and turns each CPU bus cycle into memory
// chip selects and strobes. The 24-bit address {bank_addr, address} is decoded
// into ROM, RAM or I/O. The CPU is held off by pulling rdy low for a
// per-region number of fast clocks. All logic runs on the fast FPGA clock.
// The CPU cycle is followed by sampling the phi2 level.
//
// Ports
//   clk            in   fast FPGA clock
//   internal_reset in   asynchronous, active-high reset
//   phi2           in   CPU phase-2 level, synchronous to clk
//   bank_addr[7:0] in   A23..A16
//   address[15:0]  in   A15..A0
//   re_n           in   read enable, active low
//   we_n           in   write enable, active low
//   vp_n           in   vector pull, active low
//   rdy            out  CPU ready (1 = proceed)
//   rom_ce_n       out  ROM chip select, active low
//   ram_ce_n       out  RAM chip select, active low
//   io_ce_n        out  I/O chip select, active low
//   mem_oe_n       out  memory output enable, active low
//   mem_we_n       out  memory write strobe, active low
//   region[1:0]    out  latched region: 0 none, 1 ROM, 2 RAM, 3 I/O
//   cycle_done     out  one-clk pulse at the end of each decoded cycle
//   bus_err        out  sticky flag, set when re_n and we_n are both low at
//                       cycle start
// -----------------------------------------------------------------------------
module mem_cycle_controller #(
  parameter logic [3:0] ROM_WAIT     = 4'd2,
  parameter logic [3:0] RAM_WAIT     = 4'd0,
  parameter logic [3:0] IO_WAIT      = 4'd3,
  parameter logic [7:0] RAM_TOP_BANK = 8'h07
) (
  input  logic        clk,
  input  logic        internal_reset,
  input  logic        phi2,
  input  logic [7:0]  bank_addr,
  input  logic [15:0] address,
  input  logic        re_n,
  input  logic        we_n,
  input  logic        vp_n,
  output logic        rdy,
  output logic        rom_ce_n,
  output logic        ram_ce_n,
  output logic        io_ce_n,
  output logic        mem_oe_n,
  output logic        mem_we_n,
  output logic [1:0]  region,
  output logic        cycle_done,
  output logic        bus_err
);

  localparam logic [1:0] REGION_NONE = 2'd0;
  localparam logic [1:0] REGION_ROM  = 2'd1;
  localparam logic [1:0] REGION_RAM  = 2'd2;
  localparam logic [1:0] REGION_IO   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t      state_reg;
  logic [3:0]  count_reg;
  logic        phi2_q;

  // Combinational decode of the current bus inputs. These values are only
  // used at the clk edge where a cycle start is seen.
  logic [23:0] full_addr;
  logic [1:0]  dec_region;
  logic [3:0]  dec_wait;
  logic        cycle_start;
  logic        is_read;
  logic        is_write;

  assign full_addr   = {bank_addr, address};
  assign cycle_start = phi2 & ~phi2_q;

  // A read wins when both strobes are low. That case also raises bus_err.
  assign is_read  = ~re_n;
  assign is_write = re_n & ~we_n;

  // Priority decode: vector pull first. Next comes the I/O page, then the
  // top 8K of bank 0. The RAM banks follow, and anything left is unmapped.
  always_comb begin
    dec_region = REGION_NONE;
    if (!vp_n) begin
      dec_region = REGION_ROM;
    end else if (full_addr[23:16] == 8'h00 && full_addr[15:8] == 8'hDF) begin
      dec_region = REGION_IO;
    end else if (full_addr[23:16] == 8'h00 && full_addr[15:0] >= 16'hE000) begin
      dec_region = REGION_ROM;
    end else if (full_addr[23:16] <= RAM_TOP_BANK) begin
      dec_region = REGION_RAM;
    end
  end

  always_comb begin
    dec_wait = 4'd0;
    case (dec_region)
      REGION_ROM: dec_wait = ROM_WAIT;
      REGION_RAM: dec_wait = RAM_WAIT;
      REGION_IO:  dec_wait = IO_WAIT;
      default:    dec_wait = 4'd0;
    endcase
  end

  always_ff @(posedge clk or posedge internal_reset) begin
    if (internal_reset) begin
      state_reg  <= IDLE;
      count_reg  <= 4'd0;
      phi2_q     <= 1'b0;
      rdy        <= 1'b1;
      rom_ce_n   <= 1'b1;
      ram_ce_n   <= 1'b1;
      io_ce_n    <= 1'b1;
      mem_oe_n   <= 1'b1;
      mem_we_n   <= 1'b1;
      region     <= REGION_NONE;
      cycle_done <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      phi2_q     <= phi2;
      cycle_done <= 1'b0;

      case (state_reg)
        IDLE: begin
          // A start with neither strobe active is an idle CPU cycle. The
          // controller stays put and leaves every output as it is.
          if (cycle_start && (is_read || is_write)) begin
            region   <= dec_region;
            rom_ce_n <= ~(dec_region == REGION_ROM);
            ram_ce_n <= ~(dec_region == REGION_RAM);
            io_ce_n  <= ~(dec_region == REGION_IO);
            mem_oe_n <= ~is_read;
            mem_we_n <= ~is_write;
            if (!re_n && !we_n) begin
              bus_err <= 1'b1;
            end
            count_reg <= dec_wait;
            rdy       <= (dec_wait == 4'd0);
            state_reg <= (dec_wait == 4'd0) ? HOLD : ACCESS;
          end
        end

        ACCESS: begin
          // rdy rises on the edge that sees count 1. With a load of W this
          // keeps rdy low for exactly W clocks. An early phi2 fall is
          // ignored here, and HOLD picks it up on its first clock.
          if (count_reg == 4'd1) begin
            count_reg <= 4'd0;
            rdy       <= 1'b1;
            state_reg <= HOLD;
          end else begin
            count_reg <= count_reg - 4'd1;
          end
        end

        HOLD: begin
          // Strobes are kept until the registered phi2 shows the CPU has
          // left phase 2. region keeps its value for inspection afterwards.
          if (!phi2_q) begin
            rom_ce_n   <= 1'b1;
            ram_ce_n   <= 1'b1;
            io_ce_n    <= 1'b1;
            mem_oe_n   <= 1'b1;
            mem_we_n   <= 1'b1;
            cycle_done <= 1'b1;
            state_reg  <= IDLE;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_cycle_controller.sv
module tb_mem_cycle_controller;

  logic        clk;
  logic        internal_reset;
  logic        phi2;
  logic [7:0]  bank_addr;
  logic [15:0] address;
  logic        re_n;
  logic        we_n;
  logic        vp_n;
  logic        rdy;
  logic        rom_ce_n;
  logic        ram_ce_n;
  logic        io_ce_n;
  logic        mem_oe_n;
  logic        mem_we_n;
  logic [1:0]  region;
  logic        cycle_done;
  logic        bus_err;

  int compared;
  int mismatched;

  mem_cycle_controller dut (
    .clk            (clk),
    .internal_reset (internal_reset),
    .phi2           (phi2),
    .bank_addr      (bank_addr),
    .address        (address),
    .re_n           (re_n),
    .we_n           (we_n),
    .vp_n           (vp_n),
    .rdy            (rdy),
    .rom_ce_n       (rom_ce_n),
    .ram_ce_n       (ram_ce_n),
    .io_ce_n        (io_ce_n),
    .mem_oe_n       (mem_oe_n),
    .mem_we_n       (mem_we_n),
    .region         (region),
    .cycle_done     (cycle_done),
    .bus_err        (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one CPU cycle: phi2 high for 6 clks, then low for 6 clks.
  // ce is {rom_ce_n, ram_ce_n, io_ce_n}, sampled on the first clk after
  // the start edge. rdy is counted low over the phi2-high window. Also
  // records when cycle_done is seen and the outputs present at that moment.
  task automatic run_cycle(
    input string       tag,
    input logic [7:0]  b,
    input logic [15:0] a,
    input logic        r,
    input logic        w,
    input logic        v,
    input logic [2:0]  exp_ce,
    input logic        exp_oe,
    input logic        exp_we,
    input logic [1:0]  exp_region,
    input int          exp_rdy_low,
    input int          exp_done,
    input logic        exp_err
  );
    int rdy_low;
    int done_cnt;
    int done_at;
    logic [4:0] rel;
    @(negedge clk);
    bank_addr = b; address = a; re_n = r; we_n = w; vp_n = v; phi2 = 1'b1;
    @(negedge clk);
    check({tag, ".ce"},     {29'd0, rom_ce_n, ram_ce_n, io_ce_n}, {29'd0, exp_ce});
    check({tag, ".oe"},     {31'd0, mem_oe_n}, {31'd0, exp_oe});
    check({tag, ".we"},     {31'd0, mem_we_n}, {31'd0, exp_we});
    check({tag, ".region"}, {30'd0, region},   {30'd0, exp_region});
    rdy_low = (rdy == 1'b0) ? 1 : 0;
    for (int i = 1; i < 6; i++) begin
      @(negedge clk);
      if (rdy == 1'b0) rdy_low++;
    end
    check({tag, ".rdy_low"}, rdy_low, exp_rdy_low);
    phi2 = 1'b0; re_n = 1'b1; we_n = 1'b1; vp_n = 1'b1;
    done_cnt = 0;
    done_at  = -1;
    rel      = 5'b00000;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (cycle_done) begin
        done_cnt++;
        done_at = i;
        rel = {rom_ce_n, ram_ce_n, io_ce_n, mem_oe_n, mem_we_n};
      end
    end
    check({tag, ".done_cnt"}, done_cnt, exp_done);
    if (exp_done == 1) begin
      // phi2_q falls one edge after phi2, and HOLD releases on the next.
      check({tag, ".done_at"}, done_at, 2);
      check({tag, ".released"}, {27'd0, rel}, {27'd0, 5'b11111});
    end
    check({tag, ".bus_err"}, {31'd0, bus_err}, {31'd0, exp_err});
    $display("cycle %s bank=%02h addr=%04h re_n=%0b we_n=%0b vp_n=%0b rdy_low=%0d done=%0d region=%0d",
             tag, b, a, r, w, v, rdy_low, done_cnt, region);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    internal_reset = 1'b1;
    phi2 = 1'b0; bank_addr = 8'h00; address = 16'h0000;
    re_n = 1'b1; we_n = 1'b1; vp_n = 1'b1;

    repeat (3) @(negedge clk);
    check("rst.rdy",    {31'd0, rdy}, 32'd1);
    check("rst.ce",     {29'd0, rom_ce_n, ram_ce_n, io_ce_n}, 32'd7);
    check("rst.strobe", {30'd0, mem_oe_n, mem_we_n}, 32'd3);
    check("rst.region", {30'd0, region}, 32'd0);
    check("rst.done",   {31'd0, cycle_done}, 32'd0);
    check("rst.err",    {31'd0, bus_err}, 32'd0);
    $display("reset state sampled rdy=%0b region=%0d bus_err=%0b", rdy, region, bus_err);
    internal_reset = 1'b0;

    //        tag          bank   addr      re    we    vp    ce      oe    we    reg  rdy done err
    run_cycle("ram_rd",    8'h01, 16'h1234, 1'b0, 1'b1, 1'b1, 3'b101, 1'b0, 1'b1, 2'd2, 0, 1, 1'b0);
    run_cycle("io_wr",     8'h00, 16'hDF10, 1'b1, 1'b0, 1'b1, 3'b110, 1'b1, 1'b0, 2'd3, 3, 1, 1'b0);
    run_cycle("vp_rd",     8'h05, 16'hFFEA, 1'b0, 1'b1, 1'b0, 3'b011, 1'b0, 1'b1, 2'd1, 2, 1, 1'b0);
    // Idle cycle: outputs keep their values, so region stays at ROM.
    run_cycle("idle",      8'h01, 16'h1234, 1'b1, 1'b1, 1'b1, 3'b111, 1'b1, 1'b1, 2'd1, 0, 0, 1'b0);
    run_cycle("rom_e000",  8'h00, 16'hE000, 1'b0, 1'b1, 1'b1, 3'b011, 1'b0, 1'b1, 2'd1, 2, 1, 1'b0);
    run_cycle("ram_deff",  8'h00, 16'hDEFF, 1'b0, 1'b1, 1'b1, 3'b101, 1'b0, 1'b1, 2'd2, 0, 1, 1'b0);
    run_cycle("io_dfff",   8'h00, 16'hDFFF, 1'b0, 1'b1, 1'b1, 3'b110, 1'b0, 1'b1, 2'd3, 3, 1, 1'b0);
    run_cycle("ram_b07",   8'h07, 16'hDF10, 1'b1, 1'b0, 1'b1, 3'b101, 1'b1, 1'b0, 2'd2, 0, 1, 1'b0);
    run_cycle("none_b08",  8'h08, 16'h0000, 1'b0, 1'b1, 1'b1, 3'b111, 1'b0, 1'b1, 2'd0, 0, 1, 1'b0);
    run_cycle("ram_wr",    8'h02, 16'h4000, 1'b1, 1'b0, 1'b1, 3'b101, 1'b1, 1'b0, 2'd2, 0, 1, 1'b0);
    run_cycle("none_b10",  8'h10, 16'h8000, 1'b0, 1'b1, 1'b1, 3'b111, 1'b0, 1'b1, 2'd0, 0, 1, 1'b0);
    run_cycle("both_low",  8'h01, 16'h0100, 1'b0, 1'b0, 1'b1, 3'b101, 1'b0, 1'b1, 2'd2, 0, 1, 1'b1);
    run_cycle("err_stick", 8'h02, 16'h0200, 1'b1, 1'b0, 1'b1, 3'b101, 1'b1, 1'b0, 2'd2, 0, 1, 1'b1);

    // Reset in the middle of an I/O wait: everything must drop at once.
    @(negedge clk);
    bank_addr = 8'h00; address = 16'hDF20; re_n = 1'b0; we_n = 1'b1; vp_n = 1'b1; phi2 = 1'b1;
    @(negedge clk);
    check("midrst.pre_rdy", {31'd0, rdy}, 32'd0);
    check("midrst.pre_ce",  {29'd0, rom_ce_n, ram_ce_n, io_ce_n}, 32'd6);
    #2 internal_reset = 1'b1;
    #1;
    check("midrst.rdy",    {31'd0, rdy}, 32'd1);
    check("midrst.ce",     {29'd0, rom_ce_n, ram_ce_n, io_ce_n}, 32'd7);
    check("midrst.strobe", {30'd0, mem_oe_n, mem_we_n}, 32'd3);
    check("midrst.region", {30'd0, region}, 32'd0);
    check("midrst.err",    {31'd0, bus_err}, 32'd0);
    $display("mid-access reset rdy=%0b ce=%0b%0b%0b bus_err=%0b", rdy, rom_ce_n, ram_ce_n, io_ce_n, bus_err);
    @(negedge clk);
    phi2 = 1'b0; re_n = 1'b1;
    @(negedge clk);
    internal_reset = 1'b0;

    run_cycle("post_rst",  8'h00, 16'hDF10, 1'b1, 1'b0, 1'b1, 3'b110, 1'b1, 1'b0, 2'd3, 3, 1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
